out_drain_ctrl: RTL and testbench
=================================

// Module: out_drain_ctrl
// PURPOSE
//  Parametrised successor of the output-drain controller. After each kernel pass (k_fin) it
//  walks channels 0..od, issuing accumulator reads (ra) and output-buffer writes (oa).
//  Adds output backpressure (out_ready), a one-deep pending-pass queue and a sticky overrun
//  flag. Sits between the kernel engine and the output buffer / dst streaming path.
// PARAMETERS
//  CH_W    4   width of channel index (ct, od, ra)
//  POS_W   10  width of output-position index (wi, os)
//  ADDR_W  12  width of output-buffer address oa
//  LAT     2   cycles from drain start to first outr (accumulator settle), 1..7
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  s_init       in   1       start of new sample: wi to 0, clear overrun
//  k_init       in   1       kernel engine starts a pass (counted only, see BEHAVIOUR)
//  k_fin        in   1       kernel pass finished, accumulators valid
//  od           in   CH_W    last channel index (channels = od+1)
//  os           in   POS_W   positions per sample (>=1)
//  out_ready    in   1       output buffer accepts the current read/write
//  outr         out  1       read/write valid for channel ra at address oa
//  ra           out  CH_W    accumulator channel index (= ct)
//  oa           out  ADDR_W  output address = ct*os + wi
//  update       out  1       1-cycle pulse after the last channel is accepted
//  sample_done  out  1       1-cycle pulse with update when wi wraps from os-1 to 0
//  out_busy     out  1       drain active or pass pending; kernel must not k_init
//  overrun      out  1       sticky: k_fin arrived with pass already pending
// BEHAVIOUR
//  - Reset: state IDLE, ct=0, wi=0, pending=0, dly=0; all outputs 0 (oa=0, ra=0).
//  - FSM IDLE -> DELAY on k_fin or pending; DELAY holds LAT-1 cycles, then DRAIN.
//    In DELAY outr=0. In DRAIN outr=1 every cycle; ct advances only on outr&out_ready.
//    Latency: k_fin in cycle t -> first outr in cycle t+LAT (out_ready ignored before).
//  - DRAIN end: accept with ct==od -> update=1 next cycle; ct<=0; wi<=wi+1, or 0 when
//    wi==os-1 (sample_done=1 with update). Then DELAY if pending/k_fin else IDLE.
//  - ra, oa held stable while outr & !out_ready. oa computed ct*os+wi at full width,
//    truncated to ADDR_W (no saturation); registered with ct/wi, no extra latency.
//  - k_fin outside IDLE: pending<=1. If pending already 1: overrun<=1, pass dropped.
//    k_fin on the final-accept cycle counts as pending (no overrun) and restarts DELAY.
//  - out_busy = (state!=IDLE) | pending; rises the cycle after k_fin.
//  - k_init while out_busy: ignored by the block; sets overrun (protocol violation).
//  - s_init in IDLE with no pending: wi<=0, overrun<=0 next cycle. s_init while busy:
//    latched, applied at drain end (wi<=0 instead of increment, no sample_done).
//  - od=0: one-channel drain, update 1 cycle after the single accept.
//    os=1: wi stays 0, sample_done with every update.
//  - od, os sampled at drain start (DELAY entry) and held for the drain.
//  - rst asserted mid-drain: immediate return to reset values, pending/overrun lost.
// TESTING
//  1 LAT=2, od=3, os=5, out_ready=1, k_fin@t0 -> outr t2..t5, ra 0..3, oa 0,5,10,15,
//    update@t6, wi=1 after.
//  2 Same, out_ready low at t3,t4 -> ra=1/oa=5 held t3..t5, last accept t7, update@t8.
//  3 os=3, 3 passes -> oa base wi 0,1,2; sample_done with third update; 4th pass wi=0.
//  4 k_fin mid-drain -> pending, out_busy stays 1, next DELAY right after update, no
//    gap beyond LAT; two extra k_fin mid-drain -> overrun=1, cleared by idle s_init.
//  5 od=0, os=1 -> one outr, oa=0, update and sample_done same cycle each pass.
//  6 rst pulse during DRAIN (async, mid-cycle) -> outr/out_busy/update 0 immediately,
//    ct=wi=0; next k_fin drains normally from ct=0.

Source files
------------

// File: rtl/out_drain_ctrl.sv
// Output-drain controller: after each kernel pass, walks channels 0..od issuing
// accumulator reads / output-buffer writes with backpressure, one-deep pass queue and overrun flag.
module out_drain_ctrl #(
  parameter int CH_W   = 4,
  parameter int POS_W  = 10,
  parameter int ADDR_W = 12,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_init,
  input  logic              k_init,
  input  logic              k_fin,
  input  logic [CH_W-1:0]   od,
  input  logic [POS_W-1:0]  os,
  input  logic              out_ready,
  output logic              outr,
  output logic [CH_W-1:0]   ra,
  output logic [ADDR_W-1:0] oa,
  output logic              update,
  output logic              sample_done,
  output logic              out_busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, DELAY, DRAIN} state_t;

  // LAT=1 skips DELAY entirely; otherwise DELAY lasts LAT-1 cycles.
  localparam logic [2:0] DLY_END  = (LAT > 1) ? 3'(LAT - 2) : 3'd0;
  localparam state_t     START_ST = (LAT > 1) ? DELAY : DRAIN;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_dly;
  logic [CH_W-1:0]     r_ct, r_od;
  logic [POS_W-1:0]    r_wi, r_os, w_wi_nxt;
  logic [ADDR_W-1:0]   r_oa;
  logic                r_pend, r_spend, r_overrun, r_update, r_sdone;
  logic                w_acc, w_last, w_busy, w_idle_clr, w_sreq, w_wrap, w_start;

  assign w_acc      = (r_state == DRAIN) & out_ready;
  assign w_last     = w_acc & (r_ct == r_od);
  assign w_busy     = (r_state != IDLE) | r_pend;
  assign w_idle_clr = (r_state == IDLE) & ~r_pend & s_init;
  assign w_sreq     = r_spend | s_init;
  assign w_wrap     = (r_wi == r_os - POS_W'(1));
  assign w_start    = (((r_state == IDLE) | w_last) & (k_fin | r_pend));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = START_ST;
      DELAY:   if (r_dly == DLY_END) w_state_nxt = DRAIN;
      DRAIN:   if (w_last) w_state_nxt = w_start ? START_ST : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wi_nxt = r_wi;
    if (w_last)          w_wi_nxt = (w_sreq | w_wrap) ? '0 : r_wi + POS_W'(1);
    else if (w_idle_clr) w_wi_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dly     <= '0;
      r_ct      <= '0;
      r_od      <= '0;
      r_wi      <= '0;
      r_os      <= '0;
      r_oa      <= '0;
      r_pend    <= 1'b0;
      r_spend   <= 1'b0;
      r_overrun <= 1'b0;
      r_update  <= 1'b0;
      r_sdone   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wi     <= w_wi_nxt;
      r_update <= w_last;
      r_sdone  <= w_last & ~w_sreq & w_wrap;

      if (r_state == DELAY) r_dly <= r_dly + 3'd1;

      // oa = ct*os + wi kept incrementally: base wi at start, +os per accepted channel.
      if (w_acc & ~w_last) begin
        r_ct <= r_ct + CH_W'(1);
        r_oa <= r_oa + ADDR_W'(r_os);
      end else if (w_last) begin
        r_ct <= '0;
        r_oa <= '0;
      end

      if (w_start) begin
        r_od  <= od;
        r_os  <= os;
        r_ct  <= '0;
        r_dly <= '0;
        r_oa  <= ADDR_W'(w_wi_nxt);
      end

      // One pass may be queued; the queued one is consumed by the restart.
      if (w_last | (r_state == IDLE)) r_pend <= r_pend & k_fin;
      else if (k_fin)                 r_pend <= 1'b1;

      if (w_last)                r_spend <= 1'b0;
      else if (w_busy & s_init)  r_spend <= 1'b1;

      if (w_idle_clr)
        r_overrun <= 1'b0;
      else if ((k_fin & r_pend & (r_state != IDLE) & ~w_last) | (k_init & w_busy))
        r_overrun <= 1'b1;
    end
  end

  assign outr        = (r_state == DRAIN);
  assign ra          = r_ct;
  assign oa          = r_oa;
  assign update      = r_update;
  assign sample_done = r_sdone;
  assign out_busy    = w_busy;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_out_drain_ctrl.sv
// Directed bench for out_drain_ctrl (LAT=2): drain timing, backpressure, wrap, pending, reset.
module tb_out_drain_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        s_init = 0, k_init = 0, k_fin = 0, out_ready = 1;
  logic [3:0]  od = 0;
  logic [9:0]  os = 1;
  logic        outr, update, sample_done, out_busy, overrun;
  logic [3:0]  ra;
  logic [11:0] oa;
  int total = 0, bad = 0;

  out_drain_ctrl #(.CH_W(4), .POS_W(10), .ADDR_W(12), .LAT(2)) dut (
    .clk(clk), .rst(rst), .s_init(s_init), .k_init(k_init), .k_fin(k_fin),
    .od(od), .os(os), .out_ready(out_ready), .outr(outr), .ra(ra), .oa(oa),
    .update(update), .sample_done(sample_done), .out_busy(out_busy), .overrun(overrun));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; s_init = 0; k_init = 0; k_fin = 0; out_ready = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; #2;
    total++;
    if ({outr, ra, oa, update, sample_done, out_busy, overrun} !== 21'd0) begin
      bad++; $display("FAIL reset outputs got=%0h exp=0",
                      {outr, ra, oa, update, sample_done, out_busy, overrun});
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset(); od = 3; os = 5;
    for (int c = 0; c < 8; c++) begin
      k_fin = (c == 0);
      @(negedge clk);
      total++;
      if (outr !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL basic_outr c=%0d got=%0b", c, outr); end
      total++;
      if (update !== (c == 6)) begin bad++; $display("FAIL basic_update c=%0d got=%0b", c, update); end
      total++;
      if (out_busy !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL basic_busy c=%0d got=%0b", c, out_busy); end
      if (c >= 2 && c <= 5) begin
        total++;
        if (ra !== 4'(c - 2) || oa !== 12'((c - 2) * 5)) begin
          bad++; $display("FAIL basic_addr c=%0d got ra=%0d oa=%0d exp ra=%0d oa=%0d", c, ra, oa, c - 2, (c - 2) * 5);
        end
      end
      tick();
    end
    // second pass starts at wi=1
    for (int c = 0; c < 7; c++) begin
      k_fin = (c == 0);
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (!outr || ra !== 4'd0 || oa !== 12'd1) begin
          bad++; $display("FAIL basic_wi1 got outr=%0b ra=%0d oa=%0d exp 1/0/1", outr, ra, oa);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int ra_t [8] = '{0, 0, 0, 1, 1, 1, 2, 3};
    do_reset(); od = 3; os = 5;
    for (int c = 0; c < 10; c++) begin
      k_fin = (c == 0);
      out_ready = !(c == 3 || c == 4);
      @(negedge clk);
      total++;
      if (outr !== (c >= 2 && c <= 7)) begin bad++; $display("FAIL bp_outr c=%0d got=%0b", c, outr); end
      total++;
      if (update !== (c == 8)) begin bad++; $display("FAIL bp_update c=%0d got=%0b", c, update); end
      if (c >= 2 && c <= 7) begin
        total++;
        if (ra !== 4'(ra_t[c]) || oa !== 12'(ra_t[c] * 5)) begin
          bad++; $display("FAIL bp_addr c=%0d got ra=%0d oa=%0d exp ra=%0d oa=%0d", c, ra, oa, ra_t[c], ra_t[c] * 5);
        end
      end
      tick();
    end
    out_ready = 1;
  endtask

  task automatic test_wrap();
    do_reset(); od = 1; os = 3;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5; c++) begin
        k_fin = (c == 0);
        @(negedge clk);
        total++;
        if (outr !== (c == 2 || c == 3)) begin bad++; $display("FAIL wrap_outr p=%0d c=%0d got=%0b", p, c, outr); end
        if (c == 2 || c == 3) begin
          total++;
          if (oa !== 12'((c - 2) * 3 + (p % 3))) begin
            bad++; $display("FAIL wrap_oa p=%0d c=%0d got=%0d exp=%0d", p, c, oa, (c - 2) * 3 + (p % 3));
          end
        end
        total++;
        if (update !== (c == 4) || sample_done !== (c == 4 && p == 2)) begin
          bad++; $display("FAIL wrap_pulse p=%0d c=%0d got upd=%0b sd=%0b", p, c, update, sample_done);
        end
        tick();
      end
    end
  endtask

  task automatic test_pending();
    do_reset(); od = 3; os = 5;
    for (int c = 0; c < 12; c++) begin
      k_fin = (c == 0 || c == 3);
      @(negedge clk);
      total++;
      if (outr !== ((c >= 2 && c <= 5) || (c >= 7 && c <= 10))) begin
        bad++; $display("FAIL pend_outr c=%0d got=%0b", c, outr);
      end
      total++;
      if (out_busy !== (c >= 1 && c <= 10) || update !== (c == 6 || c == 11) || overrun !== 1'b0) begin
        bad++; $display("FAIL pend_flags c=%0d got busy=%0b upd=%0b ovr=%0b", c, out_busy, update, overrun);
      end
      if (c >= 7 && c <= 10) begin
        total++;
        if (oa !== 12'((c - 7) * 5 + 1)) begin bad++; $display("FAIL pend_oa c=%0d got=%0d exp=%0d", c, oa, (c - 7) * 5 + 1); end
      end
      tick();
    end
    // overrun via double pending, cleared by idle s_init, set again by k_init while busy
    for (int c = 0; c < 18; c++) begin
      k_fin  = (c == 0 || c == 3 || c == 4 || c == 14);
      s_init = (c == 12);
      k_init = (c == 16);
      @(negedge clk);
      total++;
      if (overrun !== ((c >= 5 && c <= 12) || c >= 17)) begin
        bad++; $display("FAIL ovr c=%0d got=%0b", c, overrun);
      end
      if (c == 11 || c == 12) begin
        total++;
        if (out_busy !== 1'b0) begin bad++; $display("FAIL ovr_busy c=%0d got=%0b exp=0", c, out_busy); end
      end
      tick();
    end
    k_fin = 0; k_init = 0; s_init = 0;
  endtask

  task automatic test_single();
    do_reset(); od = 0; os = 1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        k_fin = (c == 0);
        @(negedge clk);
        total++;
        if (outr !== (c == 2) || (c == 2 && oa !== 12'd0)) begin
          bad++; $display("FAIL single_outr p=%0d c=%0d got outr=%0b oa=%0d", p, c, outr, oa);
        end
        total++;
        if (update !== (c == 3) || sample_done !== (c == 3)) begin
          bad++; $display("FAIL single_pulse p=%0d c=%0d got upd=%0b sd=%0b", p, c, update, sample_done);
        end
        tick();
      end
    end
  endtask

  task automatic test_async_rst();
    do_reset(); od = 3; os = 5;
    // move wi off zero first
    for (int c = 0; c < 7; c++) begin k_fin = (c == 0); tick(); end
    for (int c = 0; c < 4; c++) begin k_fin = (c == 0); if (c < 3) tick(); end
    #2 rst = 1; #1;
    total++;
    if (outr !== 0 || out_busy !== 0 || update !== 0 || ra !== 0 || oa !== 0) begin
      bad++; $display("FAIL arst got outr=%0b busy=%0b upd=%0b ra=%0d oa=%0d exp all 0", outr, out_busy, update, ra, oa);
    end
    #1 rst = 0;
    tick();
    for (int c = 0; c < 7; c++) begin
      k_fin = (c == 0);
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        total++;
        if (!outr || ra !== 4'(c - 2) || oa !== 12'((c - 2) * 5)) begin
          bad++; $display("FAIL arst_drain c=%0d got outr=%0b ra=%0d oa=%0d exp ra=%0d oa=%0d", c, outr, ra, oa, c - 2, (c - 2) * 5);
        end
      end
      tick();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_pending();
    test_single();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
